// File: rtl/dag_addr_gen_if.sv
// Sequencer <-> data address generator bundle: DAG operation controls,
// ureg read/write port and the registered DM/PM address results.
interface dag_addr_gen_if #(
  parameter int unsigned AW   = 16,
  parameter int unsigned NREG = 8
);
  localparam int unsigned IW = $clog2(NREG);

  logic          ps_dg_en;
  logic          ps_dg_dgsclt;
  logic          ps_dg_mdfy;
  logic [IW-1:0] ps_dg_iadd;
  logic [IW-1:0] ps_dg_madd;
  logic          ps_dg_wrt_en;
  logic [4:0]    ps_dg_wrt_add;
  logic [4:0]    ps_dg_rd_add;
  logic [AW-1:0] bc_dt;
  logic [AW-1:0] dg_bc_dt;
  logic [AW-1:0] dg_dm_add;
  logic          dg_dm_vld;
  logic [AW-1:0] dg_ps_add;
  logic          dg_pm_vld;

  modport master (
    output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
           ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    input  dg_bc_dt, dg_dm_add, dg_dm_vld, dg_ps_add, dg_pm_vld
  );

  modport slave (
    input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
           ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    output dg_bc_dt, dg_dm_add, dg_dm_vld, dg_ps_add, dg_pm_vld
  );
endinterface

// File: rtl/dag_addr_gen.sv
// Data address generator: 8 I/M/L/B register sets, pre/post-modify with
// circular-buffer wrap, registered DM or PM effective address output.
module dag_addr_gen #(
  parameter int unsigned AW   = 16,
  parameter int unsigned NREG = 8
) (
  input logic           clk,
  input logic           rst,
  dag_addr_gen_if.slave bus
);
  localparam int unsigned IW = $clog2(NREG);

  typedef enum logic [1:0] {
    CLS_I = 2'd0,
    CLS_M = 2'd1,
    CLS_L = 2'd2,
    CLS_B = 2'd3
  } ureg_cls_e;

  logic [AW-1:0] i_reg [NREG];
  logic [AW-1:0] m_reg [NREG];
  logic [AW-1:0] l_reg [NREG];
  logic [AW-1:0] b_reg [NREG];

  logic [AW-1:0] dm_add_q, ps_add_q;
  logic          dm_vld_q, pm_vld_q;

  logic [AW-1:0] mod_i, ea, rd_data;
  ureg_cls_e     wr_cls, rd_cls;
  logic [IW-1:0] wr_idx, rd_idx;

  // Single-correction circular modify; sign of the 17-bit sum marks underflow.
  function automatic logic [AW-1:0] circ(input logic [AW-1:0] i, input logic [AW-1:0] m,
                                         input logic [AW-1:0] l, input logic [AW-1:0] b);
    logic [AW:0]   s;
    logic [AW:0]   lim;
    logic [AW-1:0] res;
    s   = {1'b0, i} + {m[AW-1], m};
    lim = {1'b0, b} + {1'b0, l};
    res = s[AW-1:0];
    if (l != '0) begin
      if (!m[AW-1]) begin
        if (s >= lim) res = AW'(s - {1'b0, l});
      end else if (s[AW] || (s[AW-1:0] < b)) begin
        res = s[AW-1:0] + l;
      end
    end
    return res;
  endfunction

  always_comb begin
    mod_i = circ(i_reg[bus.ps_dg_iadd], m_reg[bus.ps_dg_madd],
                 l_reg[bus.ps_dg_iadd], b_reg[bus.ps_dg_iadd]);
    ea    = bus.ps_dg_mdfy ? mod_i : i_reg[bus.ps_dg_iadd];
  end

  assign wr_cls = ureg_cls_e'(bus.ps_dg_wrt_add[4:3]);
  assign wr_idx = IW'(bus.ps_dg_wrt_add[2:0]);
  assign rd_cls = ureg_cls_e'(bus.ps_dg_rd_add[4:3]);
  assign rd_idx = IW'(bus.ps_dg_rd_add[2:0]);

  always_comb begin
    rd_data = '0;
    case (rd_cls)
      CLS_I: rd_data = i_reg[rd_idx];
      CLS_M: rd_data = m_reg[rd_idx];
      CLS_L: rd_data = l_reg[rd_idx];
      CLS_B: rd_data = b_reg[rd_idx];
      default: rd_data = '0;
    endcase
  end

  // Ureg writes are placed after the post-modify update so they win on collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dm_add_q <= '0;
      ps_add_q <= '0;
      dm_vld_q <= 1'b0;
      pm_vld_q <= 1'b0;
    end else begin
      dm_vld_q <= 1'b0;
      pm_vld_q <= 1'b0;
      if (bus.ps_dg_en) begin
        if (bus.ps_dg_dgsclt) begin
          ps_add_q <= ea;
          pm_vld_q <= 1'b1;
        end else begin
          dm_add_q <= ea;
          dm_vld_q <= 1'b1;
        end
        if (!bus.ps_dg_mdfy) i_reg[bus.ps_dg_iadd] <= mod_i;
      end
      if (bus.ps_dg_wrt_en) begin
        case (wr_cls)
          CLS_I: i_reg[wr_idx] <= bus.bc_dt;
          CLS_M: m_reg[wr_idx] <= bus.bc_dt;
          CLS_L: l_reg[wr_idx] <= bus.bc_dt;
          CLS_B: begin
            b_reg[wr_idx] <= bus.bc_dt;
            i_reg[wr_idx] <= bus.bc_dt;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dg_bc_dt  = rd_data;
  assign bus.dg_dm_add = dm_add_q;
  assign bus.dg_dm_vld = dm_vld_q;
  assign bus.dg_ps_add = ps_add_q;
  assign bus.dg_pm_vld = pm_vld_q;

endmodule
